// File: rtl/tmr_mem_ctrl.sv
// tmr_mem_ctrl: sole initiator of the TMR SRAM. Host requests and a periodic
// background scrubber share the array; every read is a 3-cycle same-address burst.
// Ports:
//   clk, rst (async, active-low)
//   scrub_en                            background scrub enable
//   req_valid/req_ready/req_we/req_addr/req_wdata   host request port
//   rsp_valid/rsp_rdata                 host read response
//   scrub_busy/scrub_wrap               scrubber status
//   mem_enable/mem_we/mem_addr/mem_wdata/mem_rdata  SRAM side
module tmr_mem_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int SCRUB_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              scrub_busy,
    output logic              scrub_wrap,
    output logic              mem_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        FIX,
        VERIFY
    } state_t;

    // One extra bit so SCRUB_PERIOD=1 still yields a legal 1-bit timer.
    localparam int TW = $clog2(SCRUB_PERIOD + 1);
    localparam logic [TW-1:0] TMAX = TW'(SCRUB_PERIOD - 1);

    state_t state;
    state_t nxt;
    logic nxt_src;
    logic accept;
    logic pending;
    logic start_scrub;
    logic [TW-1:0] timer;
    logic [ADDR_W-1:0] scrub_addr;
    logic [DATA_W-1:0] rd_data;

    assign req_ready   = rst && (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign pending     = (timer == TMAX);
    // Host always wins; a pending scrub only starts on a request-free idle cycle.
    assign start_scrub = (state == IDLE) && scrub_en && pending && !req_valid;

    always_comb begin
        nxt     = state;
        nxt_src = scrub_busy;
        unique case (state)
            IDLE: begin
                nxt_src = start_scrub;
                if (accept) begin
                    nxt = req_we ? WR : RD;
                end else if (start_scrub) begin
                    nxt = RD;
                end
            end
            WR:     nxt = IDLE;
            RD:     nxt = FIX;
            FIX:    nxt = VERIFY;
            VERIFY: begin
                nxt     = IDLE;
                nxt_src = 1'b0;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_enable <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            scrub_busy <= 1'b0;
            scrub_wrap <= 1'b0;
            scrub_addr <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rd_data    <= '0;
            timer      <= '0;
        end else begin
            state      <= nxt;
            mem_enable <= (nxt != IDLE);
            mem_we     <= (nxt == WR);
            scrub_busy <= nxt_src;
            rsp_valid  <= 1'b0;
            scrub_wrap <= 1'b0;

            // Address is latched once per burst and held, so the array's
            // write-back during FIX/VERIFY hits the address just read.
            if (accept) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end else if (start_scrub) begin
                mem_addr <= scrub_addr;
            end

            if (state == FIX) begin
                rd_data <= mem_rdata;
            end

            if (state == VERIFY) begin
                if (scrub_busy) begin
                    scrub_addr <= scrub_addr + 1'b1;
                    scrub_wrap <= &scrub_addr;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rd_data;
                end
            end

            // Counts idle cycles only, saturating at TMAX to hold the pending scrub.
            if (!scrub_en || start_scrub) begin
                timer <= '0;
            end else if (state == IDLE && !pending) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tmr_mem_ctrl.sv
// tb_tmr_mem_ctrl: bench for tmr_mem_ctrl with a triple-copy voting SRAM
// stand-in and a transaction-level expected-memory model.
module tb_tmr_mem_ctrl;

    localparam int P = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic scrub_en = 1'b0;
    logic req_valid = 1'b0;
    logic req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic req_ready;
    logic rsp_valid;
    logic [7:0] rsp_rdata;
    logic scrub_busy;
    logic scrub_wrap;
    logic mem_enable;
    logic mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_exp [256];
    logic [7:0] last_rd = '0;

    logic [7:0] c0 [256];
    logic [7:0] c1 [256];
    logic [7:0] c2 [256];
    logic fix_pend;
    logic [7:0] fix_val;
    logic flip_en = 1'b0;
    int flip_c = 0;
    logic [7:0] flip_a = '0;
    logic [7:0] flip_v = '0;

    tmr_mem_ctrl #(
        .ADDR_W(8),
        .DATA_W(8),
        .SCRUB_PERIOD(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scrub_en(scrub_en),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .scrub_busy(scrub_busy),
        .scrub_wrap(scrub_wrap),
        .mem_enable(mem_enable),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] vote(logic [7:0] a, logic [7:0] b,
                                        logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // SRAM stand-in: synchronous voted read; a detected mismatch is written
    // back one cycle later to whatever address is then presented.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) begin
                c0[i] <= '0;
                c1[i] <= '0;
                c2[i] <= '0;
            end
            fix_pend  <= 1'b0;
            fix_val   <= '0;
            mem_rdata <= '0;
        end else begin
            if (flip_en) begin
                case (flip_c)
                    0: c0[flip_a] <= flip_v;
                    1: c1[flip_a] <= flip_v;
                    default: c2[flip_a] <= flip_v;
                endcase
            end
            if (mem_enable && mem_we) begin
                c0[mem_addr] <= mem_wdata;
                c1[mem_addr] <= mem_wdata;
                c2[mem_addr] <= mem_wdata;
                fix_pend <= 1'b0;
            end else if (mem_enable) begin
                mem_rdata <= vote(c0[mem_addr], c1[mem_addr], c2[mem_addr]);
                fix_val   <= vote(c0[mem_addr], c1[mem_addr], c2[mem_addr]);
                fix_pend  <= (c0[mem_addr] != c1[mem_addr]) ||
                             (c1[mem_addr] != c2[mem_addr]);
                if (fix_pend) begin
                    c0[mem_addr] <= fix_val;
                    c1[mem_addr] <= fix_val;
                    c2[mem_addr] <= fix_val;
                end
            end else begin
                fix_pend <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic flip(input int c, input logic [7:0] a, input logic [7:0] v);
        flip_c  = c;
        flip_a  = a;
        flip_v  = v;
        flip_en = 1'b1;
        @(negedge clk);
        flip_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the transaction.
    task automatic host_op(input logic we, input logic [7:0] a,
                           input logic [7:0] d);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("acc_to", 32'(0), 32'(1));
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (we) begin
            chk("wr_bus", 32'({mem_enable, mem_we, scrub_busy, mem_addr}),
                32'({3'b110, a}));
            chk("wr_data", 32'(mem_wdata), 32'(d));
            mem_exp[a] = d;
            @(negedge clk);
            chk("wr_end", 32'({mem_enable, rsp_valid}), 32'(0));
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge clk);
                chk("rd_bus", 32'({mem_enable, mem_we, scrub_busy, rsp_valid,
                    mem_addr}), 32'({4'b1000, a}));
            end
            @(negedge clk);
            chk("rsp_v", 32'({rsp_valid, mem_enable}), 32'(2'b10));
            chk("rsp_d", 32'(rsp_rdata), 32'(mem_exp[a]));
            last_rd = mem_exp[a];
        end
    endtask

    task automatic wait_scrub(output int cyc);
        cyc = 0;
        while (!scrub_busy && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        if (!scrub_busy) chk("scr_to", 32'(0), 32'(1));
    endtask

    // Entered at the negedge of the RD cycle of a scrub burst.
    task automatic scrub_burst(input logic [7:0] a);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("scr_bus", 32'({scrub_busy, mem_enable, mem_we, rsp_valid,
                mem_addr}), 32'({4'b1100, a}));
        end
        @(negedge clk);
        chk("scr_end", 32'({scrub_busy, scrub_wrap, rsp_valid}),
            32'({1'b0, a == 8'hFF, 1'b0}));
        chk("rsp_hold", 32'(rsp_rdata), 32'(last_rd));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got 0 exp 1");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic seen;
        logic [7:0] sc_next;
        logic [7:0] ca [6];
        logic [7:0] a;

        for (int i = 0; i < 256; i++) mem_exp[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({req_ready, rsp_valid, scrub_busy, scrub_wrap,
            mem_enable, mem_we}), 32'(0));
        chk("rst_dat", 32'({mem_addr, mem_wdata, rsp_rdata}), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("idle_rdy", 32'(req_ready), 32'(1));

        host_op(1'b1, 8'h10, 8'hA5);
        host_op(1'b0, 8'h10, 8'h00);

        host_op(1'b1, 8'h33, 8'h3C);
        host_op(1'b1, 8'h34, 8'h77);
        flip(2, 8'h33, 8'h3D);
        host_op(1'b0, 8'h33, 8'h00);
        chk("fix33", 32'({c0[8'h33], c1[8'h33], c2[8'h33]}), 32'(24'h3C3C3C));
        chk("keep34", 32'({c0[8'h34], c1[8'h34], c2[8'h34]}), 32'(24'h777777));
        host_op(1'b0, 8'h34, 8'h00);
        chk("keep34b", 32'({c0[8'h34], c1[8'h34], c2[8'h34]}), 32'(24'h777777));

        repeat (80) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            host_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
                    8'($urandom));
        end

        for (int i = 0; i < 6; i++) begin
            ca[i] = 8'(i * 40 + $urandom_range(0, 39));
            flip($urandom_range(0, 2), ca[i],
                 mem_exp[ca[i]] ^ (8'd1 << $urandom_range(0, 7)));
        end
        scrub_en = 1'b1;
        sc_next = '0;
        for (int k = 0; k < 256; k++) begin
            wait_scrub(cyc);
            chk("scr_gap", 32'(cyc), 32'(P));
            scrub_burst(sc_next);
            sc_next++;
        end
        for (int i = 0; i < 6; i++) begin
            a = ca[i];
            chk("scr_fix", 32'({c0[a], c1[a], c2[a]}),
                32'({mem_exp[a], mem_exp[a], mem_exp[a]}));
        end

        repeat (P - 1) @(negedge clk);
        host_op(1'b0, 8'h10, 8'h00);
        @(negedge clk);
        chk("scr_after_host", 32'(scrub_busy), 32'(1));
        scrub_burst(sc_next);
        sc_next++;

        wait_scrub(cyc);
        chk("scr_gap2", 32'(cyc), 32'(P));
        repeat (2) @(negedge clk);
        scrub_en = 1'b0;
        @(negedge clk);
        chk("drop_end", 32'({scrub_busy, rsp_valid}), 32'(0));
        sc_next++;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= scrub_busy;
        end
        chk("scr_off", 32'(seen), 32'(0));
        scrub_en = 1'b1;
        wait_scrub(cyc);
        chk("scr_restart", 32'(cyc), 32'(P));
        scrub_burst(sc_next);
        sc_next++;

        repeat (60) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            host_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        scrub_en = 1'b0;
        repeat (6) @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h10;
        chk("rst_acc", 32'(req_ready), 32'(1));
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("fix_en", 32'(mem_enable), 32'(1));
        rst = 1'b0;
        #1;
        chk("rst_async", 32'({mem_enable, req_ready, scrub_busy}), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("rst_norsp", 32'(seen), 32'(0));
        chk("rst_idle", 32'({req_ready, mem_enable}), 32'(2'b10));
        chk("rst_rdata", 32'(rsp_rdata), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
